// File: rtl/core_types_pkg.sv
// Shared core types: physical register tags plus the free-list pointer and
// checkpoint index types used by dispatch.
package core_types_pkg;

   localparam int unsigned NUM_PHYS_REGS   = 64;
   localparam int unsigned NUM_ARCH_REGS   = 32;
   localparam int unsigned FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int unsigned NUM_CHECKPOINTS = 4;

   localparam int unsigned TAG_W  = $clog2(NUM_PHYS_REGS);
   localparam int unsigned IDX_W  = $clog2(FREE_LIST_DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;
   localparam int unsigned CKPT_W = $clog2(NUM_CHECKPOINTS);

   typedef logic [TAG_W-1:0]  phys_reg_tag_t;
   typedef logic [PTR_W-1:0]  free_list_ptr_t;
   typedef logic [CKPT_W-1:0] checkpoint_index_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags. Dispatch takes tags from the
// head, commit returns tags at the tail, and branch checkpoints snapshot the
// head so a mispredict returns squashed tags to the list in one cycle.
module phys_reg_free_list
   import core_types_pkg::*;
(
   input  logic              CLK,
   input  logic              nRST,
   output logic              DUT_error,
   output logic              dequeue_valid,
   output logic [TAG_W-1:0]  dequeue_phys_reg_tag,
   input  logic              dequeue_ready,
   input  logic              enqueue_valid,
   input  logic [TAG_W-1:0]  enqueue_phys_reg_tag,
   input  logic              checkpoint_save_valid,
   input  logic [CKPT_W-1:0] checkpoint_save_index,
   input  logic              checkpoint_restore_valid,
   input  logic [CKPT_W-1:0] checkpoint_restore_index
);

   localparam free_list_ptr_t DEPTH_PTR = free_list_ptr_t'(FREE_LIST_DEPTH);

   phys_reg_tag_t  list_q  [FREE_LIST_DEPTH];
   phys_reg_tag_t  list_d  [FREE_LIST_DEPTH];
   free_list_ptr_t head_q, head_d;
   free_list_ptr_t tail_q, tail_d;
   free_list_ptr_t saved_q [NUM_CHECKPOINTS];
   free_list_ptr_t saved_d [NUM_CHECKPOINTS];
   logic           err_q, err_d;

   logic empty, full, deq_fire, enq_ok, restore_overflow;

   assign empty = (head_q == tail_q);
   assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                  (head_q[IDX_W] != tail_q[IDX_W]);

   assign dequeue_valid        = ~empty;
   assign dequeue_phys_reg_tag = list_q[head_q[IDX_W-1:0]];
   assign DUT_error            = err_q;

   // Next-state for pointers, array, checkpoints and the protocol-error flag.
   always_comb begin
      list_d           = list_q;
      saved_d          = saved_q;
      head_d           = head_q;
      tail_d           = tail_q;
      restore_overflow = 1'b0;

      deq_fire = ~empty & dequeue_ready & ~checkpoint_restore_valid;
      // Illegal enqueues (full list or tag 0) are dropped so tail never advances.
      enq_ok   = enqueue_valid & ~full & (enqueue_phys_reg_tag != '0);

      if (deq_fire) begin
         head_d = head_q + 1'b1;
      end
      if (enq_ok) begin
         list_d[tail_q[IDX_W-1:0]] = enqueue_phys_reg_tag;
         tail_d = tail_q + 1'b1;
      end

      // Restore overrides dequeue and save; a save captures the post-dequeue head
      // so the instruction carrying the checkpoint keeps its own tag.
      if (checkpoint_restore_valid) begin
         head_d = saved_q[checkpoint_restore_index];
         restore_overflow = ((tail_d - head_d) > DEPTH_PTR);
      end else if (checkpoint_save_valid) begin
         saved_d[checkpoint_save_index] = head_d;
      end

      err_d = (enqueue_valid & full)
            | (enqueue_valid & (enqueue_phys_reg_tag == '0))
            | (dequeue_ready & empty)
            | restore_overflow;
   end

   // State registers with synchronous active-low reset; list starts full of
   // the tags not mapped to architectural registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
            list_q[i] <= TAG_W'(NUM_ARCH_REGS + i);
         end
         for (int unsigned c = 0; c < NUM_CHECKPOINTS; c++) begin
            saved_q[c] <= '0;
         end
         head_q <= '0;
         tail_q <= {1'b1, {IDX_W{1'b0}}};
         err_q  <= 1'b0;
      end else begin
         list_q  <= list_d;
         saved_q <= saved_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios followed by random traffic,
// all checked against a queue-based model of the free list where each
// checkpoint remembers the tags handed out since it was taken.
module tb_phys_reg_free_list;
   import core_types_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              DUT_error;
   logic              dequeue_valid;
   logic [TAG_W-1:0]  dequeue_phys_reg_tag;
   logic              dequeue_ready;
   logic              enqueue_valid;
   logic [TAG_W-1:0]  enqueue_phys_reg_tag;
   logic              checkpoint_save_valid;
   logic [CKPT_W-1:0] checkpoint_save_index;
   logic              checkpoint_restore_valid;
   logic [CKPT_W-1:0] checkpoint_restore_index;

   phys_reg_free_list dut (
      .CLK                      (CLK),
      .nRST                     (nRST),
      .DUT_error                (DUT_error),
      .dequeue_valid            (dequeue_valid),
      .dequeue_phys_reg_tag     (dequeue_phys_reg_tag),
      .dequeue_ready            (dequeue_ready),
      .enqueue_valid            (enqueue_valid),
      .enqueue_phys_reg_tag     (enqueue_phys_reg_tag),
      .checkpoint_save_valid    (checkpoint_save_valid),
      .checkpoint_save_index    (checkpoint_save_index),
      .checkpoint_restore_valid (checkpoint_restore_valid),
      .checkpoint_restore_index (checkpoint_restore_index)
   );

   always #5 CLK = ~CLK;

   // Model: free tags in order, plus per-checkpoint list of tags taken since save.
   int fl[$];
   int hist[4][$];
   bit hv[4];
   bit exp_err;
   int ncomp = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      dequeue_ready            = 1'b0;
      enqueue_valid            = 1'b0;
      enqueue_phys_reg_tag     = '0;
      checkpoint_save_valid    = 1'b0;
      checkpoint_save_index    = '0;
      checkpoint_restore_valid = 1'b0;
      checkpoint_restore_index = '0;
   endtask

   task automatic model_reset();
      fl.delete();
      for (int i = 0; i < 32; i++) fl.push_back(32 + i);
      for (int j = 0; j < 4; j++) begin
         hist[j].delete();
         hv[j] = 1'b1;
      end
      exp_err = 1'b0;
   endtask

   // Reset with busy inputs to show same-cycle requests are discarded.
   task automatic do_reset();
      @(negedge CLK);
      nRST                 = 1'b0;
      dequeue_ready        = 1'b1;
      enqueue_valid        = 1'b1;
      enqueue_phys_reg_tag = 6'd9;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      idle_inputs();
      model_reset();
   endtask

   task automatic check_err();
      @(negedge CLK);
      chk("error_only", DUT_error, exp_err);
   endtask

   task automatic cycle(input bit deq, input bit enq, input int etag,
                        input bit sv, input int si, input bit rs, input int ri);
      int n_old;
      int t;
      bit err;
      @(negedge CLK);
      chk("deq_valid", dequeue_valid, (fl.size() != 0));
      if (fl.size() != 0) chk("deq_tag", dequeue_phys_reg_tag, fl[0]);
      chk("dut_error", DUT_error, exp_err);

      dequeue_ready            = deq;
      enqueue_valid            = enq;
      enqueue_phys_reg_tag     = 6'(etag);
      checkpoint_save_valid    = sv;
      checkpoint_save_index    = 2'(si);
      checkpoint_restore_valid = rs;
      checkpoint_restore_index = 2'(ri);

      n_old = fl.size();
      err = (enq && (n_old == 32 || etag == 0)) || (deq && n_old == 0);
      if (rs) begin
         for (int k = hist[ri].size() - 1; k >= 0; k--) fl.push_front(hist[ri][k]);
         for (int j = 0; j < 4; j++) begin
            hist[j].delete();
            hv[j] = (j == ri);
         end
      end else begin
         if (deq && n_old > 0) begin
            t = fl.pop_front();
            for (int j = 0; j < 4; j++) begin
               if (hv[j]) begin
                  hist[j].push_back(t);
                  if (hist[j].size() > 32) hv[j] = 1'b0;
               end
            end
         end
         if (sv) begin
            hist[si].delete();
            hv[si] = 1'b1;
         end
      end
      if (enq && n_old < 32 && etag != 0) fl.push_back(etag);
      if (rs && fl.size() > 32) err = 1'b1;
      @(posedge CLK);
      exp_err = err;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      nRST = 1'b1;
      idle_inputs();
      do_reset();

      // 1: drain all 32 reset tags, then dequeue on empty raises the error.
      for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);

      // 2: enqueue 5 then 7 from empty with dispatch ready.
      cycle(1, 1, 5, 0, 0, 0, 0);
      cycle(1, 1, 7, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);

      // 3: save ckpt 2 alongside the 4th dequeue, take two more, restore.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 2, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 2);
      drain(28);

      // 4: restore with same-cycle enqueue and dequeue request.
      do_reset();
      cycle(1, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 40, 0, 0, 1, 1);
      drain(32);

      // 5: alternating dequeue/enqueue across pointer wrap.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 0, 0, 0, 0, 0);
         cycle(0, 1, 1 + (i % 60), 0, 0, 0, 0);
      end
      drain(32);

      // 6: enqueue on a full list (tag 0, then a legal tag) is flagged and dropped.
      do_reset();
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 1, 9, 0, 0, 0, 0);
      drain(32);

      // Restore that would leave more than DEPTH entries is flagged.
      do_reset();
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 40, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 3);
      check_err();

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         int n, etag, si, ri;
         bit deq, enq, sv, rs, enq_ok;
         n    = fl.size();
         deq  = (n > 0)  ? ($urandom % 2 == 0) : ($urandom % 32 == 0);
         enq  = (n < 32) ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
         etag = ($urandom % 32 == 0) ? 0 : int'($urandom_range(1, 63));
         sv   = ($urandom % 8 == 0);
         si   = int'($urandom % 4);
         ri   = int'($urandom % 4);
         enq_ok = enq && (n < 32) && (etag != 0);
         rs   = ($urandom % 12 == 0) && hv[ri] &&
                (n + hist[ri].size() + (enq_ok ? 1 : 0) <= 32);
         cycle(deq, enq, etag, sv, si, rs, ri);
      end
      cycle(0, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
